// File: rtl/lcd_fb_writer_if.sv
// lcd_fb_writer_if: per-channel core pixel stream in, frame-buffer write port out.
// master = core/frame-buffer side, slave = lcd_fb_writer. Channel c at [c*W +: W].
interface lcd_fb_writer_if #(
  parameter int CH = 2,
  parameter int DW = 15,
  parameter int AW = 15
);
  logic [CH-1:0]    ce;
  logic [CH-1:0]    lcd_clkena;
  logic [CH*DW-1:0] lcd_data;
  logic [CH*2-1:0]  lcd_mode;
  logic [CH-1:0]    lcd_on;
  logic [CH-1:0]    lcd_vs;
  logic [CH*AW-1:0] rd_ptr;
  logic [CH-1:0]    wr_en;
  logic [CH*AW-1:0] wr_addr;
  logic [CH*DW-1:0] wr_data;
  logic [CH-1:0]    frame_done;
  logic [CH-1:0]    blanking;
  logic [CH-1:0]    pause;

  modport master (
    output ce, lcd_clkena, lcd_data, lcd_mode,
    output lcd_on, lcd_vs, rd_ptr,
    input  wr_en, wr_addr, wr_data,
    input  frame_done, blanking, pause
  );

  modport slave (
    input  ce, lcd_clkena, lcd_data, lcd_mode,
    input  lcd_on, lcd_vs, rd_ptr,
    output wr_en, wr_addr, wr_data,
    output frame_done, blanking, pause
  );
endinterface

// File: rtl/lcd_fb_writer.sv
// lcd_fb_writer: CH independent pixel-stream to frame-buffer writers with
// blank-frame regeneration while the LCD is off and a scan-out pause request.
// Ports: clk_sys, reset_n (async, active low), bus (lcd_fb_writer_if.slave).
module lcd_fb_writer #(
  parameter int CH        = 2,
  parameter int W         = 160,
  parameter int H         = 144,
  parameter int DW        = 15,
  parameter int LINE_CYC  = 456,
  parameter int LINES     = 154,
  parameter int RD_MARK   = 11521,
  parameter int WR_MARK   = 4801,
  parameter int PAUSE_LEN = 255
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  lcd_fb_writer_if.slave bus
);
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  // pointer must be able to hold NPIX itself (saturation value)
  localparam int PW   = AW + 1;
  localparam int HW   = $clog2(LINE_CYC);
  localparam int VW   = $clog2(LINES);
  localparam int CW   = $clog2(PAUSE_LEN + 1);

  typedef enum logic {S_LIVE, S_BLANK} state_t;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_rd;
    logic          w_on;
    logic          w_off;
    logic          w_hit;
    logic          w_wr;
    logic          w_tick;
    logic          w_hend;
    logic          w_wrap;
    logic          w_match;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [CW-1:0] r_pcnt;
    logic [DW-1:0] r_blank_data;
    logic          r_blank_de;
    logic          r_off;
    logic          r_on;
    logic          r_vs;
    logic          r_wr_en;
    logic          r_frame_done;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;

    assign w_data  = bus.lcd_data[c*DW +: DW];
    assign w_rd    = bus.rd_ptr[c*AW +: AW];
    assign w_on    = bus.lcd_on[c];
    assign w_off   = !w_on || (bus.lcd_mode[c*2 +: 2] == 2'd1);
    assign w_hit   = bus.ce[c] & (bus.lcd_clkena[c] | r_blank_de);
    assign w_wr    = w_hit && (r_ptr < PW'(NPIX));
    assign w_tick  = (r_state == S_BLANK) && bus.ce[c] && !w_on;
    assign w_hend  = (r_hcnt == HW'(LINE_CYC - 1));
    assign w_wrap  = w_tick && w_hend &&
                     (r_vcnt == VW'(LINES - 1));
    assign w_match = (w_rd == AW'(RD_MARK)) &&
                     (r_ptr > PW'(WR_MARK));

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_state      <= S_LIVE;
        r_ptr        <= '0;
        r_hcnt       <= '0;
        r_vcnt       <= '0;
        r_pcnt       <= '0;
        r_blank_data <= '0;
        r_blank_de   <= 1'b0;
        r_off        <= 1'b0;
        r_on         <= 1'b0;
        r_vs         <= 1'b0;
        r_wr_en      <= 1'b0;
        r_frame_done <= 1'b0;
        r_wr_addr    <= '0;
        r_wr_data    <= '0;
      end else begin
        r_off <= w_off;
        r_on  <= w_on;
        r_vs  <= bus.lcd_vs[c];

        r_wr_en      <= w_wr;
        r_frame_done <= w_wr && (r_ptr == PW'(NPIX - 1));
        if (w_wr) begin
          r_wr_addr <= r_ptr[AW-1:0];
          r_wr_data <= (w_on && r_state == S_BLANK) ?
                       r_blank_data : w_data;
        end

        // a clear wins; the hit above still lands at the old address
        if ((w_off != r_off) || w_wrap)
          r_ptr <= '0;
        else if (w_wr)
          r_ptr <= r_ptr + PW'(1);

        r_blank_de <= (r_state == S_BLANK) && !w_on &&
                      (r_hcnt < HW'(W)) && (r_vcnt < VW'(H));

        unique case (r_state)
          S_LIVE: begin
            if (r_on && !w_on) begin
              r_state <= S_BLANK;
              r_hcnt  <= '0;
              r_vcnt  <= '0;
            end
          end
          S_BLANK: begin
            if (w_tick) begin
              r_blank_data <= w_data;
              if (w_hend) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == VW'(LINES - 1)) ?
                          '0 : r_vcnt + VW'(1);
              end else begin
                r_hcnt <= r_hcnt + HW'(1);
              end
            end
            if (bus.lcd_vs[c] && !r_vs)
              r_state <= S_LIVE;
          end
        endcase

        if (w_match)
          r_pcnt <= CW'(PAUSE_LEN);
        else if (r_pcnt != '0)
          r_pcnt <= r_pcnt - CW'(1);
      end
    end

    assign bus.wr_en[c]             = r_wr_en;
    assign bus.wr_addr[c*AW +: AW]  = r_wr_addr;
    assign bus.wr_data[c*DW +: DW]  = r_wr_data;
    assign bus.frame_done[c]        = r_frame_done;
    assign bus.blanking[c]          = (r_state == S_BLANK);
    assign bus.pause[c]             = (r_pcnt != '0);
  end
endmodule

// File: tb/tb_lcd_fb_writer.sv
// tb_lcd_fb_writer: random stimulus against a behavioural per-channel model.
// Blank timing is shortened (LINE_CYC/LINES) to keep the run compact.
module tb_lcd_fb_writer;
  localparam int CH  = 2;
  localparam int W   = 160;
  localparam int H   = 144;
  localparam int DW  = 15;
  localparam int LC  = 168;
  localparam int LN  = 146;
  localparam int RDM = 11521;
  localparam int WRM = 4801;
  localparam int PL  = 255;
  localparam int N   = W * H;
  localparam int AW  = $clog2(N);

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  lcd_fb_writer_if #(.CH(CH), .DW(DW), .AW(AW)) bus ();

  lcd_fb_writer #(
    .CH(CH), .W(W), .H(H), .DW(DW),
    .LINE_CYC(LC), .LINES(LN),
    .RD_MARK(RDM), .WR_MARK(WRM), .PAUSE_LEN(PL)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  logic          s_ce[CH];
  logic          s_clk[CH];
  logic          s_on[CH];
  logic          s_vs[CH];
  logic [1:0]    s_mode[CH];
  logic [DW-1:0] s_data[CH];
  logic [AW-1:0] s_rd[CH];

  for (genvar c = 0; c < CH; c++) begin : g_drv
    assign bus.ce[c]                = s_ce[c];
    assign bus.lcd_clkena[c]        = s_clk[c];
    assign bus.lcd_on[c]            = s_on[c];
    assign bus.lcd_vs[c]            = s_vs[c];
    assign bus.lcd_mode[c*2 +: 2]   = s_mode[c];
    assign bus.lcd_data[c*DW +: DW] = s_data[c];
    assign bus.rd_ptr[c*AW +: AW]   = s_rd[c];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // reference model: pointer, blank-frame position, last pause match time
  int m_ptr[CH], m_bpos[CH], m_bdata[CH], m_last[CH];
  bit m_blank[CH], m_bde[CH], m_pon[CH], m_poff[CH], m_pvs[CH];
  bit e_wr[CH], e_fd[CH], e_pause[CH];
  int e_addr[CH], e_data[CH];
  int cyc = 0;
  int n_wr[CH], n_fd[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ptr[c] = 0; m_bpos[c] = 0; m_bdata[c] = 0;
      m_last[c] = -1000000;
      m_blank[c] = 0; m_bde[c] = 0;
      m_pon[c] = 0; m_poff[c] = 0; m_pvs[c] = 0;
      e_wr[c] = 0; e_fd[c] = 0; e_pause[c] = 0;
      e_addr[c] = 0; e_data[c] = 0;
    end
  endtask

  task automatic model_step();
    bit off, hit, clr, nbde;
    int np;
    for (int c = 0; c < CH; c++) begin
      off = !s_on[c] || (s_mode[c] == 2'd1);
      hit = s_ce[c] && (s_clk[c] || m_bde[c]);
      e_wr[c] = hit && (m_ptr[c] < N);
      e_fd[c] = e_wr[c] && (m_ptr[c] == N - 1);
      if (e_wr[c]) begin
        e_addr[c] = m_ptr[c];
        e_data[c] = (s_on[c] && m_blank[c]) ? m_bdata[c] : int'(s_data[c]);
      end
      if (int'(s_rd[c]) == RDM && m_ptr[c] > WRM) m_last[c] = cyc;
      e_pause[c] = (cyc - m_last[c]) < PL;
      np = m_ptr[c] + (e_wr[c] ? 1 : 0);
      clr = (off != m_poff[c]);
      nbde = m_blank[c] && !s_on[c] &&
             (m_bpos[c] % LC) < W && (m_bpos[c] / LC) < H;
      if (m_blank[c] && s_ce[c] && !s_on[c]) begin
        m_bdata[c] = int'(s_data[c]);
        if (m_bpos[c] == LC * LN - 1) begin
          m_bpos[c] = 0;
          clr = 1;
        end else begin
          m_bpos[c]++;
        end
      end
      if (!m_blank[c] && m_pon[c] && !s_on[c]) begin
        m_blank[c] = 1;
        m_bpos[c] = 0;
      end else if (m_blank[c] && s_vs[c] && !m_pvs[c]) begin
        m_blank[c] = 0;
      end
      m_bde[c] = nbde;
      m_ptr[c] = clr ? 0 : np;
      m_poff[c] = off;
      m_pon[c] = s_on[c];
      m_pvs[c] = s_vs[c];
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (reset_n) model_step();
    else model_reset();
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("ch%0d ctl", c),
          {28'd0, bus.wr_en[c], bus.frame_done[c],
           bus.blanking[c], bus.pause[c]},
          {28'd0, e_wr[c], e_fd[c], m_blank[c], e_pause[c]});
      if (e_wr[c]) begin
        chk($sformatf("ch%0d addr", c),
            32'(bus.wr_addr[c*AW +: AW]), e_addr[c]);
        chk($sformatf("ch%0d data", c),
            32'(bus.wr_data[c*DW +: DW]), e_data[c]);
      end
      n_wr[c] += int'(bus.wr_en[c]);
      n_fd[c] += int'(bus.frame_done[c]);
    end
  endtask

  function automatic logic [AW-1:0] rnd_rd();
    int v;
    v = $urandom_range(0, (1 << AW) - 1);
    if (v == RDM) v = 0;
    return AW'(v);
  endfunction

  function automatic logic [1:0] rnd_mode();
    int m;
    m = $urandom_range(0, 2);
    return (m == 0) ? 2'd0 : 2'(m + 1);
  endfunction

  task automatic ch1_idle();
    s_ce[1] = 1'($urandom_range(0, 1));
    s_clk[1] = 1'b0;
    s_on[1] = 1'b1;
    s_vs[1] = 1'b0;
    s_mode[1] = 2'd0;
    s_data[1] = DW'($urandom);
    s_rd[1] = rnd_rd();
  endtask

  initial begin
    int str, np1, np2;
    bit done_live;
    logic [DW-1:0] bd;
    for (int c = 0; c < CH; c++) begin
      s_ce[c] = 0; s_clk[c] = 0; s_on[c] = 1; s_vs[c] = 0;
      s_mode[c] = 0; s_data[c] = 0; s_rd[c] = 0;
      n_wr[c] = 0; n_fd[c] = 0;
    end
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst ctl", {24'd0, bus.wr_en, bus.frame_done,
                    bus.blanking, bus.pause}, 0);
    chk("rst addr", 32'(bus.wr_addr), 0);
    chk("rst data", 32'(bus.wr_data), 0);
    reset_n = 1'b1;

    // live frame plus saturation on channel 0, channel 1 idle
    str = 0;
    done_live = 0;
    while (str < N + 5) begin
      s_ce[0] = 1'b1;
      s_clk[0] = ($urandom_range(0, 7) != 0);
      s_data[0] = DW'($urandom);
      s_mode[0] = rnd_mode();
      s_vs[0] = 1'($urandom_range(0, 1));
      s_rd[0] = AW'($urandom_range(0, (1 << AW) - 1));
      ch1_idle();
      if (s_clk[0]) str++;
      tick();
      if (str == N && !done_live) begin
        done_live = 1;
        chk("live writes", n_wr[0], N);
        chk("live fdone", n_fd[0], 1);
      end
    end
    s_clk[0] = 1'b0;
    tick();
    chk("sat writes", n_wr[0], N);
    chk("ch1 idle", n_wr[1], 0);

    // ch0 blank frame; ch1 pause scenarios in parallel
    bd = DW'($urandom);
    s_on[0] = 1'b0; s_clk[0] = 1'b0; s_vs[0] = 1'b0;
    s_mode[0] = 2'd0; s_data[0] = bd; s_ce[0] = 1'b1;
    s_rd[0] = rnd_rd();
    n_wr[0] = 0;
    np1 = 0;
    np2 = 0;
    for (int j = 0; j < LC * LN + 1; j++) begin
      s_rd[0] = rnd_rd();
      ch1_idle();
      s_ce[1] = 1'b1;
      if (j < 4802) s_clk[1] = 1'b1;
      if (j == 4802) s_rd[1] = AW'(RDM);
      if (j == 5200) s_mode[1] = 2'd1;
      if (j >= 5210 && j < 10011) s_clk[1] = 1'b1;
      if (j == 10011) s_rd[1] = AW'(RDM);
      if (j >= 10500) begin
        s_ce[1] = ($urandom_range(0, 3) != 0);
        s_clk[1] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 40) == 0) s_rd[1] = AW'(RDM);
      end
      tick();
      if (j == 0) chk("blank enter", 32'(bus.blanking[0]), 1);
      if (j >= 4802 && j < 5200) np1 += int'(bus.pause[1]);
      if (j >= 10011 && j < 10400) np2 += int'(bus.pause[1]);
    end
    chk("blank writes", n_wr[0], N);
    chk("pause len", np1, PL);
    chk("pause none", np2, 0);

    // LCD back on: still blanking until vsync, strobes use latched data
    ch1_idle();
    s_on[0] = 1'b1;
    tick();
    chk("blank hold", 32'(bus.blanking[0]), 1);
    repeat (3) begin
      s_clk[0] = 1'b1;
      s_data[0] = DW'($urandom);
      tick();
    end
    s_clk[0] = 1'b0;
    s_vs[0] = 1'b1;
    tick();
    chk("vs exit", 32'(bus.blanking[0]), 0);
    s_vs[0] = 1'b0;

    // pointer now 3; bring it to 10 then clear with a same-cycle strobe
    repeat (7) begin
      s_clk[0] = 1'b1;
      s_data[0] = DW'($urandom);
      tick();
    end
    s_mode[0] = 2'd1;
    s_data[0] = DW'($urandom);
    tick();
    chk("prio wr", 32'(bus.wr_en[0]), 1);
    chk("prio old addr", 32'(bus.wr_addr[AW-1:0]), 10);
    tick();
    chk("prio new addr", 32'(bus.wr_addr[AW-1:0]), 0);
    s_mode[0] = 2'd0;
    s_clk[0] = 1'b0;
    tick();

    // asynchronous reset in the middle of a write burst
    s_clk[0] = 1'b1;
    s_clk[1] = 1'b1;
    s_ce[1] = 1'b1;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst ctl", {24'd0, bus.wr_en, bus.frame_done,
                     bus.blanking, bus.pause}, 0);
    chk("arst addr", 32'(bus.wr_addr), 0);
    tick();
    reset_n = 1'b1;
    s_data[0] = DW'($urandom);
    tick();
    chk("post rst wr", 32'(bus.wr_en[0]), 1);
    chk("post rst addr", 32'(bus.wr_addr[AW-1:0]), 0);
    s_clk[0] = 1'b0;
    s_clk[1] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
